// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the EX-stage multiply/divide unit.
package cpu_pkg;

  localparam int unsigned MDU_ITER  = 32;
  localparam int unsigned MDU_CNT_W = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIN  = 2'b10
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Unsigned magnitude; 0x80000000 maps onto itself, which is the correct magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// EX-stage <-> multiply/divide unit signal bundle.
interface ex_mdu_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hilo_rd;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall_req;

  modport master (
    output start, op, rs_val, rt_val, hilo_rd, hi_we, lo_we, wdata, flush,
    input  hi, lo, busy, done, stall_req
  );

  modport slave (
    input  start, op, rs_val, rt_val, hilo_rd, hi_we, lo_we, wdata, flush,
    output hi, lo, busy, done, stall_req
  );
endinterface

// File: rtl/mdu_iter_dp.sv
// Iterative datapath: shift-add multiply / restoring divide on unsigned
// magnitudes, one iteration per clock.
// Multiply: acc = {partial, multiplier}, result acc = product.
// Divide:   acc = {remainder, dividend/quotient}, result {rem, quot}.
module mdu_iter_dp import cpu_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] init_lo,
  input  logic [31:0] opnd_in,
  output logic [63:0] acc
);

  logic [31:0] opnd;
  logic [32:0] mul_sum;
  logic [32:0] div_rem;
  logic [32:0] div_diff;

  // One iteration's candidate values for both operations.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
    div_rem  = {acc[63:32], acc[31]};
    div_diff = div_rem - {1'b0, opnd};
  end

  // Accumulator load and per-cycle iteration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc  <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= {32'd0, init_lo};
      opnd <= opnd_in;
    end else if (step) begin
      if (is_div)
        acc <= div_diff[32] ? {div_rem[31:0], acc[30:0], 1'b0}
                            : {div_diff[31:0], acc[30:0], 1'b1};
      else
        acc <= {mul_sum, acc[31:1]};
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: FSM, sign handling and HI/LO registers.
//
// state   | meaning
// IDLE    | waiting for start; MTHI/MTLO writes accepted here
// CALC    | 32 datapath iterations, then one cycle to move on to FIN
// FIN     | sign-correct result, write HI/LO, pulse done
module ex_mdu import cpu_pkg::*; (
  input  logic    clk,
  input  logic    rst,
  ex_mdu_if.slave bus
);

  localparam logic [MDU_CNT_W-1:0] ITER_LAST = MDU_CNT_W'(MDU_ITER);

  mdu_state_e           state;
  logic [MDU_CNT_W-1:0] cnt;
  logic                 op_div, neg_rs, neg_rt, div0;
  logic [31:0]          rs_raw, hi_q, lo_q;
  logic                 busy_q, done_q;
  logic [31:0]          rs_mag, rt_mag, q_fix, r_fix;
  logic [63:0]          acc, prod_fix, fin_hilo;
  logic                 accept, dp_step, start_div, start_div0;

  // Operand magnitudes and start/step qualification.
  always_comb begin
    rs_mag     = mag32(bus.rs_val, op_is_signed(bus.op));
    rt_mag     = mag32(bus.rt_val, op_is_signed(bus.op));
    start_div  = op_is_div(bus.op);
    start_div0 = start_div && (bus.rt_val == 32'd0);
    accept     = (state == ST_IDLE) && bus.start && !bus.flush;
    dp_step    = (state == ST_CALC) && (cnt != ITER_LAST) && !bus.flush;
  end

  mdu_iter_dp u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .step    (dp_step),
    .is_div  (op_div),
    .init_lo (start_div ? rs_mag : rt_mag),
    .opnd_in (start_div ? rt_mag : rs_mag),
    .acc     (acc)
  );

  // Sign correction of the unsigned result; divide by zero bypasses the datapath.
  always_comb begin
    prod_fix = (neg_rs ^ neg_rt) ? (~acc + 64'd1) : acc;
    q_fix    = (neg_rs ^ neg_rt) ? (~acc[31:0] + 32'd1) : acc[31:0];
    r_fix    = neg_rs ? (~acc[63:32] + 32'd1) : acc[63:32];
    if (div0)
      fin_hilo = {rs_raw, 32'hFFFF_FFFF};
    else if (op_div)
      fin_hilo = {r_fix, q_fix};
    else
      fin_hilo = prod_fix;
  end

  // Sequencing FSM with registered busy/done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_div <= 1'b0;
      neg_rs <= 1'b0;
      neg_rt <= 1'b0;
      div0   <= 1'b0;
      rs_raw <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_div <= start_div;
            neg_rs <= op_is_signed(bus.op) & bus.rs_val[31];
            neg_rt <= op_is_signed(bus.op) & bus.rt_val[31];
            div0   <= start_div0;
            rs_raw <= bus.rs_val;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= start_div0 ? ST_FIN : ST_CALC;
          end
        end
        ST_CALC: begin
          if (bus.flush) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (cnt == ITER_LAST) begin
            state <= ST_FIN;
          end else begin
            cnt <= cnt + MDU_CNT_W'(1);
          end
        end
        ST_FIN: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= !bus.flush;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // HI/LO: result write in FIN, MTHI/MTLO only while idle; a squashed EX instruction writes nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == ST_FIN && !bus.flush) begin
      hi_q <= fin_hilo[63:32];
      lo_q <= fin_hilo[31:0];
    end else if (state == ST_IDLE && !bus.flush) begin
      if (bus.hi_we) hi_q <= bus.wdata;
      if (bus.lo_we) lo_q <= bus.wdata;
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stall_req = busy_q & (bus.start | bus.hilo_rd | bus.hi_we | bus.lo_we);

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: expected HI/LO and completion cycle are
// queued at issue time and checked by an independent done monitor.
module tb_ex_mdu;
  import cpu_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          e0;

  logic [1:0]  d_op[5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
  logic [31:0] d_a[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
  logic [31:0] d_b[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF};
  logic [31:0] d_hi[5] = '{32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd7, 32'd0};
  logic [31:0] d_lo[5] = '{32'd1, 32'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};

  ex_mdu_if bus();

  ex_mdu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero like MIPS.
  function automatic logic [63:0] ref_mdu(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2'b00)      r = 64'(sa * sb);
    else if (op == 2'b01) r = {32'd0, a} * {32'd0, b};
    else if (b == 32'd0)  r = {a, 32'hFFFF_FFFF};
    else if (op == 2'b10) r = {32'(sa % sb), 32'(sa / sb)};
    else                  r = {a % b, a / b};
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic push_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int edge0);
    logic [63:0] r;
    exp_t        e;
    r     = ref_mdu(op, a, b);
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.cyc = edge0 + ((op[1] && b == 32'd0) ? 1 : 34);
    exp_q.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
  endtask

  // Call at a negedge with the unit idle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input bit hwe, input bit lwe, input logic [31:0] wd);
    bus.op = op; bus.rs_val = a; bus.rt_val = b; bus.start = 1'b1;
    bus.hi_we = hwe; bus.lo_we = lwe; bus.wdata = wd;
    if (hwe) model_hi = wd;
    if (lwe) model_lo = wd;
    if (push) push_exp(op, a, b, cyc + 1);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    if (hwe) chk("mt_with_start_hi", bus.hi, wd);
    if (lwe) chk("mt_with_start_lo", bus.lo, wd);
    bus.rs_val = $urandom; bus.rt_val = $urandom;
    bus.op = 2'($urandom_range(0, 3)); bus.wdata = $urandom;
  endtask

  task automatic mt_write(input bit hwe, input bit lwe, input logic [31:0] wd);
    bus.hi_we = hwe; bus.lo_we = lwe; bus.wdata = wd;
    if (hwe) model_hi = wd;
    if (lwe) model_lo = wd;
    @(posedge clk);
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    chk("mt_hi", bus.hi, model_hi);
    chk("mt_lo", bus.lo, model_lo);
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 80; k++) begin
      if (exp_q.size() == 0 && !bus.busy) break;
      @(negedge clk);
      #1;
    end
    if (k == 80) begin
      n_chk++; n_fail++;
      $display("FAIL wait_done: timeout with %0d results pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_flushed(input string name);
    #1;
    chk({name, "_busy"}, bus.busy, 1'b0);
    chk({name, "_hi"}, bus.hi, model_hi);
    chk({name, "_lo"}, bus.lo, model_lo);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL done_unexpected: done=1 at cycle %0d, required no pending result", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("res_hi", bus.hi, mon_e.hi);
        chk("res_lo", bus.lo, mon_e.lo);
        chk("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 32'd5; bus.rt_val = 32'd5;
    bus.hilo_rd = 1'b1; bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hFFFF_FFFF;
    bus.flush = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_stall", bus.stall_req, 1'b0);
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_stall", bus.stall_req, 1'b0);
    bus.hilo_rd = 1'b0;

    // MULT 7 x 6 with MFHI held in EX: busy/stall profile and final value.
    issue(2'b00, 32'd7, 32'd6, 1'b1, 1'b0, 1'b0, 32'd0);
    bus.hilo_rd = 1'b1;
    for (int j = 0; j <= 34; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      chk($sformatf("busy_e%0d", j), bus.busy, (j <= 33));
      chk($sformatf("stall_rd_e%0d", j), bus.stall_req, (j <= 33));
    end
    bus.hilo_rd = 1'b0;
    chk("mult7x6_hi", bus.hi, 32'd0);
    chk("mult7x6_lo", bus.lo, 32'd42);
    wait_done();

    // Directed corner operations against literal results.
    for (int i = 0; i < 5; i++) begin
      issue(d_op[i], d_a[i], d_b[i], 1'b1, 1'b0, 1'b0, 32'd0);
      wait_done();
      chk($sformatf("dir%0d_hi", i), bus.hi, d_hi[i]);
      chk($sformatf("dir%0d_lo", i), bus.lo, d_lo[i]);
    end

    mt_write(1'b1, 1'b0, 32'h1234_5678);
    mt_write(1'b0, 1'b1, 32'h9ABC_DEF0);

    // Start while busy is ignored; held start is taken the edge after busy drops.
    issue(2'b00, 32'd123456, 32'hFFFF_0001, 1'b1, 1'b0, 1'b1, 32'h0BAD_F00D);
    e0 = cyc;
    repeat (5) @(negedge clk);
    bus.op = 2'b01; bus.rs_val = 32'hDEAD_BEEF; bus.rt_val = 32'h0000_1235; bus.start = 1'b1;
    push_exp(2'b01, 32'hDEAD_BEEF, 32'h0000_1235, e0 + 35);
    for (int j = 5; j <= 34; j++) begin
      if (j > 5) @(negedge clk);
      #1;
      chk($sformatf("stall_start_e%0d", j), bus.stall_req, (j <= 33));
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Flush at CALC iteration 10.
    mt_write(1'b1, 1'b1, 32'h5A5A_1234);
    issue(2'b01, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check_flushed("flush_calc");
    repeat (40) @(negedge clk);
    check_flushed("flush_calc_late");

    // Flush in FIN of a full operation and of a divide by zero.
    issue(2'b10, 32'hFFFF_0000, 32'd3, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (33) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check_flushed("flush_fin");
    issue(2'b11, 32'h55, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check_flushed("flush_div0");
    repeat (3) @(negedge clk);

    // Flush beats start in IDLE.
    bus.op = 2'b00; bus.rs_val = 32'd9; bus.rt_val = 32'd9; bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check_flushed("flush_start");
    repeat (3) @(negedge clk);

    // Asynchronous reset at iteration 20, then MULT 3 x 3.
    issue(2'b00, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_hi = '0;
    model_lo = '0;
    check_flushed("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check_flushed("rst_mid_late");
    issue(2'b00, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0, 32'd0);
    wait_done();
    chk("mult3x3_lo", bus.lo, 32'd9);
    chk("mult3x3_hi", bus.hi, 32'd0);

    // Randomized operations, some with MTHI/MTLO in the start cycle and idle gaps.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] rop;
      logic       hwe, lwe;
      rop = 2'($urandom_range(0, 3));
      hwe = ($urandom_range(0, 3) == 0);
      lwe = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 4) == 0) mt_write(1'b1, 1'b1, $urandom);
      issue(rop, pick(), pick(), 1'b1, hwe, lwe, $urandom);
      wait_done();
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
